// File: rtl/mcycle_pkg.sv
// mcycle_pkg: FSM state type and MCycleOp encodings shared by mcycle_unit and its divider.
package mcycle_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;
endpackage

// File: rtl/mcycle_divider.sv
// mcycle_divider: one restoring shift-subtract step on unsigned magnitudes.
module mcycle_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh    = {rem_i, quo_i[WIDTH-1]};
    diff  = sh - {1'b0, div_i};
    rem_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
  end
endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiply / shift-subtract divide.
// Divide datapath is built only when MCYCLE_DIV_EN is defined; otherwise DIV returns Err.
module mcycle_unit import mcycle_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_neg, mul_next;
  logic [WIDTH-1:0] mag_q, mag_d, res1_q, res1_d, res2_q, res2_d, abs1, abs2;
  logic [WIDTH:0] sum;
  logic neg_q, neg_d, err_q, err_d, sgn1, sgn2;
`ifdef MCYCLE_DIV_EN
  logic div_q, div_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] op1_q, op1_d, rem_n, quo_n, quo_fix, rem_fix;
  mcycle_divider #(.WIDTH(WIDTH)) u_div (
    .rem_i(acc_q[2*WIDTH-1:WIDTH]),
    .quo_i(acc_q[WIDTH-1:0]),
    .div_i(mag_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
  assign quo_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  assign sgn1     = Signed & Operand1[WIDTH-1];
  assign sgn2     = Signed & Operand2[WIDTH-1];
  assign abs1     = sgn1 ? -Operand1 : Operand1;
  assign abs2     = sgn2 ? -Operand2 : Operand2;
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {sum, acc_q[WIDTH-1:1]};
  assign acc_neg  = neg_q ? -acc_q : acc_q;
  assign Busy     = state_q == COMPUTE;
  assign Done     = state_q == DONE;
  assign Result1  = res1_q;
  assign Result2  = res2_q;
  assign Err      = err_q;
  // acc holds {high, low}: product accumulator for MUL, {remainder, quotient} for DIV
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    err_d   = err_q;
`ifdef MCYCLE_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    op1_d   = op1_q;
`endif
    unique case (state_q)
      COMPUTE: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 1'b1;
          acc_d = mul_next;
`ifdef MCYCLE_DIV_EN
          if (div_q) acc_d = {rem_n, quo_n};
`endif
        end else begin
          state_d          = DONE;
          {res2_d, res1_d} = acc_neg;
          err_d            = 1'b0;
`ifdef MCYCLE_DIV_EN
          if (div_q) begin
            res1_d = (mag_q == '0) ? '1 : quo_fix;
            res2_d = (mag_q == '0) ? op1_q : rem_fix;
            err_d  = mag_q == '0;
          end
`endif
        end
      end
      default: begin
        if (Start) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          mag_d   = abs1;
          acc_d   = {{WIDTH{1'b0}}, abs2};
          neg_d   = sgn1 ^ sgn2;
`ifdef MCYCLE_DIV_EN
          div_d   = MCycleOp == MCYCLE_DIV;
          rneg_d  = sgn1;
          op1_d   = Operand1;
          if (MCycleOp == MCYCLE_DIV) begin
            mag_d = abs2;
            acc_d = {{WIDTH{1'b0}}, abs1};
          end
`else
          if (MCycleOp == MCYCLE_DIV) begin
            state_d = DONE;
            res1_d  = '0;
            res2_d  = '0;
            err_d   = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      res1_q  <= '0;
      res2_q  <= '0;
      err_q   <= 1'b0;
`ifdef MCYCLE_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      op1_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      err_q   <= err_d;
`ifdef MCYCLE_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      op1_q   <= op1_d;
`endif
    end
  end
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed checks of mcycle_unit (WIDTH=32) with immediate assertions.
module tb_mcycle_unit;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic        MCycleOp = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1, Result2;
  logic        Busy, Done, Err;
  int errors = 0;
  int checks = 0;
  int lat;
  int pulses;
  always #5 CLK = ~CLK;
  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp), .Signed(Signed),
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .Busy(Busy), .Done(Done), .Err(Err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic op, input logic s, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MCycleOp = op; Signed = s; Operand1 = a; Operand2 = b;
    @(posedge CLK); #1;
    Start = 1'b0; MCycleOp = ~op; Signed = ~s; Operand1 = $urandom; Operand2 = $urandom;
  endtask
  task automatic wait_done(input int from);
    lat = from;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("wait_expired", Done, 1'b1);
  endtask
  task automatic check_res(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic ee, input int el);
    chk($sformatf("%s_lat", tag), lat, el);
    chk($sformatf("%s_r1", tag), Result1, e1);
    chk($sformatf("%s_r2", tag), Result2, e2);
    chk($sformatf("%s_err", tag), Err, ee);
  endtask
  task automatic count_done(input int n);
    pulses = 0;
    repeat (n) begin
      @(posedge CLK); #1;
      if (Done === 1'b1) pulses++;
    end
  endtask
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_err", Err, 1'b0);
    chk("rst_r1", Result1, 32'h0);
    chk("rst_r2", Result2, 32'h0);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    start_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_uu_busy", Busy, 1'b1);
    wait_done(0);
    check_res("mul_uu", 32'h00000001, 32'hFFFFFFFE, 1'b0, 33);
    @(posedge CLK); #1;
    chk("done_pulse", Done, 1'b0);
    chk("hold_r1", Result1, 32'h00000001);
    start_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000005);
    wait_done(0);
    check_res("mul_ss", 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 33);
`ifdef MCYCLE_DIV_EN
    start_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002);
    wait_done(0);
    check_res("div_neg7_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    start_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0);
    check_res("div_ovf", 32'h80000000, 32'h00000000, 1'b0, 33);
    start_op(1'b1, 1'b0, 32'd100, 32'd0);
    wait_done(0);
    check_res("div_u_zero", 32'hFFFFFFFF, 32'd100, 1'b1, 33);
    start_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd0);
    wait_done(0);
    check_res("div_s_zero", 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 33);
    start_op(1'b1, 1'b0, 32'd100, 32'd7);
    wait_done(0);
    check_res("div_u_100_7", 32'd14, 32'd2, 1'b0, 33);
`else
    start_op(1'b1, 1'b0, 32'd100, 32'd5);
    wait_done(0);
    check_res("div_off", 32'h0, 32'h0, 1'b1, 0);
`endif
    start_op(1'b0, 1'b0, 32'd6, 32'd7);
    wait_done(0);
    check_res("mul_after_div", 32'd42, 32'd0, 1'b0, 33);
    start_op(1'b0, 1'b0, 32'd7, 32'd7);
    repeat (4) @(posedge CLK);
    #1;
    Start = 1'b1; Operand1 = 32'd9; Operand2 = 32'd9;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(5);
    check_res("start_ignored", 32'd49, 32'd0, 1'b0, 33);
    count_done(40);
    chk("single_done", pulses, 0);
    start_op(1'b0, 1'b0, 32'd3, 32'd3);
    repeat (9) @(posedge CLK);
    #1;
    RESETn = 1'b0; Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd5; Operand2 = 32'd5;
    @(posedge CLK); #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_r1", Result1, 32'h0);
    chk("abort_r2", Result2, 32'h0);
    chk("abort_err", Err, 1'b0);
    RESETn = 1'b1; Start = 1'b0;
    count_done(40);
    chk("abort_no_done", pulses, 0);
    start_op(1'b0, 1'b0, 32'd2, 32'd3);
    wait_done(0);
    check_res("b2b_first", 32'd6, 32'd0, 1'b0, 33);
    start_op(1'b0, 1'b0, 32'd4, 32'd5);
    chk("b2b_busy", Busy, 1'b1);
    chk("b2b_done_low", Done, 1'b0);
    wait_done(0);
    check_res("b2b_second", 32'd20, 32'd0, 1'b0, 33);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 SHALL have CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have RESETn  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have Start  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have MCycleOp  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have Signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have Operand1  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL have Operand2  input  WIDTH  multiplier or divisor.
REQ-009 SHALL have Result1  output  WIDTH  product low half or quotient.
REQ-010 SHALL have Result2  output  WIDTH  product high half or remainder.
REQ-011 SHALL have Busy  output  1  high while iterating.
REQ-012 SHALL have Done  output  1  one-cycle pulse; results valid.
REQ-013 SHALL have Err  output  1  divide-by-zero or unsupported op; valid with Done.

Function
REQ-014 SHALL implement FSM IDLE -> COMPUTE -> DONE -> IDLE.
REQ-015 In IDLE or DONE with Start=1: SHALL latch operands, op and Signed, clear counter, and enter COMPUTE.
REQ-016 In DONE with Start=0: SHALL return to IDLE.
REQ-017 SHALL perform one shift-add (MUL) or shift-subtract (DIV) iteration per COMPUTE cycle, for exactly WIDTH cycles, then enter DONE.
REQ-018 Done SHALL go high exactly WIDTH+1 cycles after the edge that samples Start; Busy=1 only in COMPUTE.
REQ-019 Start during COMPUTE SHALL be ignored; input changes after acceptance SHALL NOT affect the result.
REQ-020 Result1, Result2 and Err SHALL update only on entry to DONE and hold until the next DONE.
REQ-021 MUL SHALL produce the full 2*WIDTH product, split {Result2, Result1}; signed mode uses magnitudes, then negates the product if the operand signs differ.
REQ-022 DIV SHALL truncate toward zero; remainder sign follows the dividend.
REQ-023 Divisor zero: Result1 = all ones, Result2 = dividend, Err=1 (signed and unsigned).
REQ-024 Signed most-negative / -1: Result1 = most-negative, Result2 = 0, Err=0.
REQ-025 Err SHALL be 0 for every MUL.

Reset
REQ-026 RESETn=0 at a rising edge SHALL force IDLE, counter 0, Busy=0, Done=0, Err=0, Result1=0, Result2=0.
REQ-027 Reset mid-COMPUTE SHALL abort the operation with no Done pulse; Start is ignored while RESETn=0.

Configuration
REQ-028 Macro MCYCLE_DIV_EN defined: divide datapath SHALL be present and behave per REQ-022..REQ-024.
REQ-029 Macro MCYCLE_DIV_EN undefined: no divide logic SHALL be built; a DIV request SHALL go directly to DONE on the next edge with Result1=Result2=0, Err=1; MUL is unaffected.

Structure
REQ-030 Shared package mcycle_pkg SHALL hold the FSM state typedef (IDLE/COMPUTE/DONE) and the MCycleOp encodings MCYCLE_MUL=0 and MCYCLE_DIV=1.
REQ-031 The divide iteration datapath SHALL be one sub-module, mcycle_divider, instantiated only under MCYCLE_DIV_EN; sign fix-up and the FSM stay in mcycle_unit.

Verification (WIDTH=32, macro defined unless stated)
REQ-032 Unsigned MUL 0xFFFFFFFF x 0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001, Done exactly 33 cycles after Start sampled.
REQ-033 Signed MUL -3 x 5 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFF1, Err=0.
REQ-034 Signed DIV -7 / 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; then signed 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0, Err=0.
REQ-035 Unsigned DIV 100 / 0 -> Result1=0xFFFFFFFF, Result2=100, Err=1; with macro undefined, DIV 100 / 5 -> Done next cycle, results 0, Err=1.
REQ-036 Start with a second Start pulse at COMPUTE cycle 5 -> second request ignored, one Done only; separate run with RESETn=0 at COMPUTE cycle 10 -> next cycle Busy=0, results 0, no Done.
REQ-037 Start held high in DONE -> new operation accepted back-to-back, Done again 33 cycles later.
